// File: rtl/arithmetic_logic_unit.sv
// Execution-stage ALU: registered result and {Z,C,N,O} flags, one op per Start.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for FunSel 1111.
module arithmetic_logic_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       FunSel,
    input  logic             WF,
    input  logic             Start,
    output logic [WIDTH-1:0] ALUOut,
    output logic [3:0]       FlagsOut,
    output logic             Busy,
    output logic             Done
);
    logic             c_flag, o_flag;
    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   ext;
    logic             c_new, o_new, upd_flags;
    logic             launch;

    assign c_flag = FlagsOut[2];
    assign o_flag = FlagsOut[0];

    // Single-cycle datapath; C/O default to hold so only ops that define them change them.
    always_comb begin
        res       = '0;
        ext       = '0;
        c_new     = c_flag;
        o_new     = o_flag;
        upd_flags = 1'b1;
        case (FunSel)
            4'b0000: res = A;
            4'b0001: res = B;
            4'b0010: res = ~A;
            4'b0011: res = ~B;
            4'b0100, 4'b0101: begin
                ext   = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, FunSel[0] & c_flag};
                res   = ext[WIDTH-1:0];
                c_new = ext[WIDTH];
                o_new = (A[WIDTH-1] == B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
            end
            4'b0110: begin
                ext   = {1'b0, A} - {1'b0, B};
                res   = ext[WIDTH-1:0];
                c_new = ~ext[WIDTH];
                o_new = (A[WIDTH-1] != B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
            end
            4'b0111: res = A & B;
            4'b1000: res = A | B;
            4'b1001: res = A ^ B;
            4'b1010: begin res = {A[WIDTH-2:0], 1'b0};      c_new = A[WIDTH-1]; end
            4'b1011: begin res = {1'b0, A[WIDTH-1:1]};      c_new = A[0];       end
            4'b1100: begin res = {A[WIDTH-1], A[WIDTH-1:1]}; c_new = A[0];      end
            4'b1101: begin res = {A[WIDTH-2:0], c_flag};    c_new = A[WIDTH-1]; end
            4'b1110: begin res = {c_flag, A[WIDTH-1:1]};    c_new = A[0];       end
            default: upd_flags = 1'b0;
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;
    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
    logic [CW-1:0]    count;
    logic             wf_q;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign launch   = Start && (state == IDLE) && (FunSel != 4'b1111);
`else
    assign launch = Start;
    assign Busy   = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ALUOut   <= '0;
            FlagsOut <= '0;
            Done     <= 1'b0;
`ifdef ALU_MUL_EN
            Busy     <= 1'b0;
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            count    <= '0;
            wf_q     <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            if (launch) begin
                ALUOut <= res;
                Done   <= 1'b1;
                if (WF && upd_flags)
                    FlagsOut <= {res == '0, c_new, res[WIDTH-1], o_new};
            end
`ifdef ALU_MUL_EN
            if (state == IDLE && Start && FunSel == 4'b1111) begin
                mcand  <= A;
                mplier <= B;
                acc    <= '0;
                count  <= '0;
                wf_q   <= WF;
                Busy   <= 1'b1;
                state  <= MUL;
            end
            // One multiplier bit per edge; the last step writes the product directly.
            if (state == MUL) begin
                acc    <= acc_next;
                mcand  <= {mcand[WIDTH-2:0], 1'b0};
                mplier <= {1'b0, mplier[WIDTH-1:1]};
                count  <= count + 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    ALUOut <= acc_next;
                    Done   <= 1'b1;
                    Busy   <= 1'b0;
                    state  <= IDLE;
                    if (wf_q)
                        FlagsOut <= {acc_next == '0, FlagsOut[2], acc_next[WIDTH-1], FlagsOut[0]};
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// Randomized bench for arithmetic_logic_unit against an arithmetic reference model.
module tb_arithmetic_logic_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A = '0, B = '0;
    logic [3:0]  FunSel = '0;
    logic        WF = 1'b0, Start = 1'b0;
    logic [31:0] ALUOut;
    logic [3:0]  FlagsOut;
    logic        Busy, Done;

    int vectors = 0, miscompares = 0;
    logic [31:0] m_out   = '0;
    logic [3:0]  m_flags = '0;

    arithmetic_logic_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .A(A), .B(B), .FunSel(FunSel), .WF(WF),
        .Start(Start), .ALUOut(ALUOut), .FlagsOut(FlagsOut), .Busy(Busy), .Done(Done)
    );

    always #5 clock = ~clock;

    // Reference: plain 64-bit arithmetic on the operation's definition.
    function automatic void ref_op(input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] fs, input logic wf);
        logic [31:0] r;
        logic        c, o, c_old, upd;
        longint      s, ss;
        c_old = m_flags[2];
        c = m_flags[2];
        o = m_flags[0];
        upd = 1'b1;
        r = '0;
        case (fs)
            4'd0: r = a;
            4'd1: r = b;
            4'd2: r = ~a;
            4'd3: r = ~b;
            4'd4, 4'd5: begin
                s  = longint'(a) + longint'(b) + ((fs == 4'd5 && c_old) ? 1 : 0);
                ss = longint'($signed(a)) + longint'($signed(b)) + ((fs == 4'd5 && c_old) ? 1 : 0);
                r  = s[31:0];
                c  = s > longint'(32'hFFFF_FFFF);
                o  = ss != longint'($signed(r));
            end
            4'd6: begin
                ss = longint'($signed(a)) - longint'($signed(b));
                r  = a - b;
                c  = a >= b;
                o  = ss != longint'($signed(r));
            end
            4'd7:  r = a & b;
            4'd8:  r = a | b;
            4'd9:  r = a ^ b;
            4'd10: begin r = a << 1; c = a[31]; end
            4'd11: begin r = a >> 1; c = a[0];  end
            4'd12: begin r = 32'($signed(a) >>> 1); c = a[0]; end
            4'd13: begin r = (a << 1) | {31'd0, c_old}; c = a[31]; end
            4'd14: begin r = (a >> 1) | {c_old, 31'd0}; c = a[0]; end
            default: begin
`ifdef ALU_MUL_EN
                s = longint'(a) * longint'(b);
                r = s[31:0];
`else
                r = '0;
                upd = 1'b0;
`endif
            end
        endcase
        m_out = r;
        if (wf && upd)
            m_flags = {r == 32'd0, c, r[31], o};
    endfunction

    // Presents one single-cycle op for exactly one edge; returns at the negedge after it.
    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] fs, input logic wf);
        @(negedge clock);
        A = a; B = b; FunSel = fs; WF = wf; Start = 1'b1;
        ref_op(a, b, fs, wf);
        @(negedge clock);
        Start = 1'b0; A = $urandom; B = $urandom; FunSel = 4'($urandom); WF = 1'($urandom);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clock);
        vectors++;
        if ({ALUOut, FlagsOut, Busy, Done} !== 38'd0) begin
            miscompares++;
            $display("FAIL reset_state: ALUOut=%h Flags=%b Busy=%b Done=%b, want all zero",
                     ALUOut, FlagsOut, Busy, Done);
        end
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if (Done !== 1'b0 || ALUOut !== 32'd0) begin
            miscompares++;
            $display("FAIL post_reset_idle: Done=%b ALUOut=%h, want 0 0", Done, ALUOut);
        end
    endtask

    task automatic test_directed();
        logic [32:0] want [6];
        logic [3:0]  wflg [6];
        logic [31:0] da   [6] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'h8000_0000, 32'd1};
        logic [31:0] db   [6] = '{32'h1, 32'h1, 32'h1, 32'd7, 32'h1234_5678, 32'd1};
        logic [3:0]  dfs  [6] = '{4'd4, 4'd4, 4'd4, 4'd6, 4'd13, 4'd5};
        logic        dwf  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        want = '{{1'b1, 32'h0}, {1'b1, 32'h8000_0000}, {1'b1, 32'h8000_0000},
                 {1'b1, 32'hFFFF_FFFE}, {1'b1, 32'h0}, {1'b1, 32'h3}};
        wflg = '{4'b1100, 4'b0011, 4'b0011, 4'b0010, 4'b1100, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            launch(da[i], db[i], dfs[i], dwf[i]);
            vectors++;
            if ({Done, ALUOut} !== want[i] || FlagsOut !== wflg[i]) begin
                miscompares++;
                $display("FAIL directed_%0d: Done=%b ALUOut=%h Flags=%b, want %b %h %b",
                         i, Done, ALUOut, FlagsOut, want[i][32], want[i][31:0], wflg[i]);
            end
            @(negedge clock);
            vectors++;
            if (Done !== 1'b0) begin
                miscompares++;
                $display("FAIL done_pulse_%0d: Done=%b one cycle later, want 0", i, Done);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] fs;
        for (int i = 0; i < 150; i++) begin
`ifdef ALU_MUL_EN
            fs = 4'($urandom_range(0, 14));
`else
            fs = 4'($urandom_range(0, 15));
`endif
            launch(pick_operand(), pick_operand(), fs, 1'($urandom));
            vectors++;
            if (Done !== 1'b1 || ALUOut !== m_out || FlagsOut !== m_flags) begin
                miscompares++;
                $display("FAIL random_%0d fs=%0d: Done=%b ALUOut=%h Flags=%b, want 1 %h %b",
                         i, fs, Done, ALUOut, FlagsOut, m_out, m_flags);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic [3:0]  fs;
        logic        wf;
        @(negedge clock);
        for (int i = 0; i <= 24; i++) begin
            if (i > 0) begin
                vectors++;
                if (Done !== 1'b1 || ALUOut !== m_out || FlagsOut !== m_flags) begin
                    miscompares++;
                    $display("FAIL back_to_back_%0d: Done=%b ALUOut=%h Flags=%b, want 1 %h %b",
                             i, Done, ALUOut, FlagsOut, m_out, m_flags);
                end
            end
            if (i == 24) begin
                Start = 1'b0;
            end else begin
                a = pick_operand(); b = pick_operand();
                fs = 4'($urandom_range(0, 14)); wf = 1'($urandom);
                A = a; B = b; FunSel = fs; WF = wf; Start = 1'b1;
                ref_op(a, b, fs, wf);
                @(negedge clock);
            end
        end
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul();
        logic [31:0] ma [4] = '{32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678};
        logic [31:0] mb [4] = '{32'h0001_0001, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h9ABC_DEF1};
        int busy_bad, done_cnt, done_at;
        for (int p = 0; p < 6; p++) begin
            logic [31:0] a, b;
            logic        wf;
            a  = (p < 4) ? ma[p] : $urandom;
            b  = (p < 4) ? mb[p] : $urandom;
            wf = (p == 1) ? 1'b0 : 1'b1;
            @(negedge clock);
            A = a; B = b; FunSel = 4'hF; WF = wf; Start = 1'b1;
            ref_op(a, b, 4'hF, wf);
            @(negedge clock);
            Start = 1'b0;
            busy_bad = 0; done_cnt = 0; done_at = -1;
            for (int k = 0; k < 40; k++) begin
                if (Busy !== (k < 32)) busy_bad++;
                if (Done === 1'b1) begin done_cnt++; done_at = k; end
                if (k == 32) begin
                    vectors++;
                    if (ALUOut !== m_out || FlagsOut !== m_flags) begin
                        miscompares++;
                        $display("FAIL mul_%0d_result: ALUOut=%h Flags=%b, want %h %b",
                                 p, ALUOut, FlagsOut, m_out, m_flags);
                    end
                end
                A = $urandom; B = $urandom; WF = 1'($urandom);
                if (k == 5)  begin Start = 1'b1; FunSel = 4'd4; end
                if (k == 12) begin Start = 1'b1; FunSel = 4'hF; end
                if (k == 6 || k == 13) Start = 1'b0;
                @(negedge clock);
            end
            vectors++;
            if (busy_bad != 0 || done_cnt != 1 || done_at != 32) begin
                miscompares++;
                $display("FAIL mul_%0d_timing: busy_errs=%0d done_count=%0d done_cycle=%0d, want 0 1 32",
                         p, busy_bad, done_cnt, done_at);
            end
        end
    endtask
`else
    task automatic test_no_mul();
        int busy_seen = 0;
        launch(32'hFFFF_FFFF, 32'h1, 4'd4, 1'b1);
        if (Busy !== 1'b0) busy_seen++;
        launch(32'd3, 32'd4, 4'hF, 1'b1);
        if (Busy !== 1'b0) busy_seen++;
        vectors++;
        if (Done !== 1'b1 || ALUOut !== 32'd0 || FlagsOut !== 4'b1100) begin
            miscompares++;
            $display("FAIL no_mul_op: Done=%b ALUOut=%h Flags=%b, want 1 00000000 1100",
                     Done, ALUOut, FlagsOut);
        end
        repeat (4) begin
            @(negedge clock);
            if (Busy !== 1'b0) busy_seen++;
        end
        vectors++;
        if (busy_seen != 0) begin
            miscompares++;
            $display("FAIL no_mul_busy: Busy high %0d samples, want 0", busy_seen);
        end
    endtask
`endif

    task automatic test_reset_mid_op();
        int stray = 0;
`ifdef ALU_MUL_EN
        @(negedge clock);
        A = 32'h0001_0000; B = 32'h0001_0001; FunSel = 4'hF; WF = 1'b1; Start = 1'b1;
        @(negedge clock);
        Start = 1'b0;
        repeat (9) @(negedge clock);
`else
        launch(32'h7FFF_FFFF, 32'h1, 4'd4, 1'b1);
`endif
        #2 reset = 1'b1;
        #1;
        m_out = '0; m_flags = '0;
        vectors++;
        if ({ALUOut, FlagsOut, Busy, Done} !== 38'd0) begin
            miscompares++;
            $display("FAIL async_reset: ALUOut=%h Flags=%b Busy=%b Done=%b, want all zero",
                     ALUOut, FlagsOut, Busy, Done);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (Done !== 1'b0 || Busy !== 1'b0) stray++;
        end
        vectors++;
        if (stray != 0) begin
            miscompares++;
            $display("FAIL no_done_after_reset: %0d stray Done/Busy samples, want 0", stray);
        end
        launch(32'd2, 32'd3, 4'd4, 1'b1);
        vectors++;
        if (Done !== 1'b1 || ALUOut !== 32'd5 || FlagsOut !== 4'b0000) begin
            miscompares++;
            $display("FAIL add_after_reset: Done=%b ALUOut=%h Flags=%b, want 1 00000005 0000",
                     Done, ALUOut, FlagsOut);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
`ifdef ALU_MUL_EN
        test_mul();
`else
        test_no_mul();
`endif
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
